chunked_adder: RTL and testbench

- Parametrised multi-cycle adder: successor to the fixed 4-bit combinational adder.
- Adds two WIDTH-bit operands plus carry-in, CHUNK bits per clock, under valid/ready handshakes on input and output.
- Sits between operand-producing logic and a consumer that may stall.
- Trades latency for a short carry chain.
- Produces sum, carry-out and signed-overflow flags.

---
 rtl/adder_pkg.sv | 15 +
 rtl/adder_chunk.sv | 14 +
 rtl/chunked_adder.sv | 114 +++++++++++
 tb/tb_chunked_adder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the chunked multi-cycle adder.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the chunk index register; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// CHUNK-bit combinational ripple slice: s/co = x + y + ci.
module adder_chunk #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    assign {co, s} = (CHUNK+1)'(x) + (CHUNK+1)'(y) + (CHUNK+1)'(ci);

endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle WIDTH-bit adder, CHUNK bits per clock, valid/ready on both sides.
// Define CHUNKED_ADDER_SATURATE_EN to clamp q to all ones on unsigned carry-out.
module chunked_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IW     = idx_width(NCHUNK);
    localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

    if (CHUNK == 0 || NCHUNK == 0 || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("chunked_adder: WIDTH must be a non-zero multiple of CHUNK");
    end

    state_t state, state_next;

    logic [NCHUNK-1:0][CHUNK-1:0] a_r, b_r, q_r;
    logic [IW-1:0]                idx;
    logic                         carry;
    logic [CHUNK-1:0]             s;
    logic                         co;
    logic                         last;
    logic                         msb_a, msb_b;

    assign last  = (idx == LAST);
    assign msb_a = a_r[NCHUNK-1][CHUNK-1];
    assign msb_b = b_r[NCHUNK-1][CHUNK-1];

    // Single shared slice adder, fed by the chunk selected by idx.
    adder_chunk #(.CHUNK(CHUNK)) u_chunk (
        .x  (a_r[idx]),
        .y  (b_r[idx]),
        .ci (carry),
        .s  (s),
        .co (co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign in_ready = (state == IDLE);
    assign q        = q_r;

    // Operand capture, per-chunk sum write-back and result flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r       <= '0;
            b_r       <= '0;
            q_r       <= '0;
            idx       <= '0;
            carry     <= 1'b0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= b;
                        carry <= cin;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    q_r[idx] <= s;
                    carry    <= co;
                    idx      <= last ? '0 : idx + IW'(1);
                    if (last) begin
                        cout      <= co;
                        overflow  <= (msb_a == msb_b) && (s[CHUNK-1] != msb_a);
                        out_valid <= 1'b1;
`ifdef CHUNKED_ADDER_SATURATE_EN
                        if (co) q_r <= '1;
`endif
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_chunked_adder.sv
// Self-checking bench for chunked_adder (WIDTH=16, CHUNK=4) against a plain-arithmetic model.
`timescale 1ns/1ps
module tb_chunked_adder;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned CHUNK  = 4;
    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int          BOUND  = 40;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a, b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] q;
    logic             cout;
    logic             overflow;

    int n_cmp = 0;
    int n_err = 0;

    chunked_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .cout      (cout),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Reference: whole-word arithmetic, no chunking.
    function automatic void model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                  input logic mc, output logic [WIDTH-1:0] mq,
                                  output logic mco, output logic mov);
        logic [WIDTH:0] full;
        full = {1'b0, ma} + {1'b0, mb} + {{WIDTH{1'b0}}, mc};
        mq   = full[WIDTH-1:0];
        mco  = full[WIDTH];
        mov  = (ma[WIDTH-1] == mb[WIDTH-1]) && (full[WIDTH-1] != ma[WIDTH-1]);
`ifdef CHUNKED_ADDER_SATURATE_EN
        if (mco) mq = '1;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one operand set for exactly one accept edge (assumes IDLE).
    task automatic send(input logic [WIDTH-1:0] sa, input logic [WIDTH-1:0] sb, input logic sc);
        a = sa; b = sb; cin = sc; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // Count cycles to out_valid; scramble inputs meanwhile. -1 on timeout.
    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!out_valid) begin
            if (cycles >= BOUND) begin
                cycles = -1;
                return;
            end
            a        = WIDTH'($urandom);
            b        = WIDTH'($urandom);
            cin      = 1'($urandom);
            in_valid = 1'($urandom);
            step();
            cycles++;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || q !== '0 || cout !== 1'b0 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL reset: in_ready=%b out_valid=%b q=%h cout=%b ovf=%b, want 1 0 0000 0 0",
                     in_ready, out_valid, q, cout, overflow);
        end
        step(); step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0] va [4] = '{16'h00FF, 16'hFFFF, 16'h7FFF, 16'h8000};
        logic [WIDTH-1:0] vb [4] = '{16'h0001, 16'h0001, 16'h0001, 16'h8000};
        logic             vc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
`ifdef CHUNKED_ADDER_SATURATE_EN
        logic [WIDTH-1:0] eq [4] = '{16'h0100, 16'hFFFF, 16'h8001, 16'hFFFF};
`else
        logic [WIDTH-1:0] eq [4] = '{16'h0100, 16'h0000, 16'h8001, 16'h0000};
`endif
        logic             ec [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic             eo [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(va[i], vb[i], vc[i]);
            wait_valid(lat);
            n_cmp++;
            if (lat !== NCHUNK) begin
                n_err++;
                $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, NCHUNK);
            end
            n_cmp++;
            if (q !== eq[i] || cout !== ec[i] || overflow !== eo[i]) begin
                n_err++;
                $display("FAIL dir%0d_result: q=%h cout=%b ovf=%b, want q=%h cout=%b ovf=%b",
                         i, q, cout, overflow, eq[i], ec[i], eo[i]);
            end
            step();
            n_cmp++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL dir%0d_release: in_ready=%b out_valid=%b want 1 0", i, in_ready, out_valid);
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_stall();
        int lat;
        out_ready = 1'b0;
        send(16'd5, 16'd7, 1'b0);
        wait_valid(lat);
        n_cmp++;
        if (lat !== NCHUNK) begin
            n_err++;
            $display("FAIL stall_latency: got %0d want %0d", lat, NCHUNK);
        end
        for (int i = 0; i < 5; i++) begin
            a = 16'h1234; b = 16'h4321; cin = 1'b1; in_valid = 1'b1;
            n_cmp++;
            if (q !== 16'd12 || out_valid !== 1'b1 || in_ready !== 1'b0 || cout !== 1'b0 || overflow !== 1'b0) begin
                n_err++;
                $display("FAIL stall_hold%0d: q=%0d out_valid=%b in_ready=%b, want 12 1 0", i, q, out_valid, in_ready);
            end
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || q !== 16'd12) begin
            n_err++;
            $display("FAIL stall_release: in_ready=%b out_valid=%b q=%0d, want 1 0 12", in_ready, out_valid, q);
        end
    endtask

    task automatic test_reset_midrun();
        int lat;
        send(16'd1, 16'd2, 1'b0);
        step();
        rst = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || q !== '0) begin
            n_err++;
            $display("FAIL midrun_reset: in_ready=%b out_valid=%b q=%h, want 1 0 0000", in_ready, out_valid, q);
        end
        step();
        rst = 1'b0;
        for (int i = 0; i < NCHUNK + 2; i++) step();
        n_cmp++;
        if (out_valid !== 1'b0 || q !== '0) begin
            n_err++;
            $display("FAIL midrun_quiet: out_valid=%b q=%h, want 0 0000", out_valid, q);
        end
        out_ready = 1'b1;
        send(16'd2, 16'd1, 1'b0);
        wait_valid(lat);
        n_cmp++;
        if (lat !== NCHUNK || q !== 16'd3) begin
            n_err++;
            $display("FAIL midrun_next: latency=%0d q=%0d, want %0d 3", lat, q, NCHUNK);
        end
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] ra, rb, eq;
        logic             rc, ec, eo;
        int lat, hold;
        for (int n = 0; n < 40; n++) begin
            ra = WIDTH'($urandom); rb = WIDTH'($urandom); rc = 1'($urandom);
            if (n % 8 == 0) ra = '1;
            model(ra, rb, rc, eq, ec, eo);
            send(ra, rb, rc);
            wait_valid(lat);
            n_cmp++;
            if (lat !== NCHUNK || q !== eq || cout !== ec || overflow !== eo) begin
                n_err++;
                $display("FAIL rand%0d: a=%h b=%h c=%b lat=%0d q=%h cout=%b ovf=%b, want lat=%0d q=%h cout=%b ovf=%b",
                         n, ra, rb, rc, lat, q, cout, overflow, NCHUNK, eq, ec, eo);
            end
            hold = $urandom_range(0, 3);
            for (int h = 0; h < hold; h++) begin
                step();
                n_cmp++;
                if (out_valid !== 1'b1 || q !== eq) begin
                    n_err++;
                    $display("FAIL rand%0d_hold: out_valid=%b q=%h, want 1 %h", n, out_valid, q, eq);
                end
            end
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        int first, second, cyc;
        first = -1; second = -1; cyc = 0;
        a = 16'h0F0F; b = 16'h00F1; cin = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        while (second < 0 && cyc < BOUND) begin
            if (in_ready) begin
                if (first < 0) first = cyc;
                else second = cyc;
            end
            step();
            cyc++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (second < 0 || (second - first) !== NCHUNK + 2) begin
            n_err++;
            $display("FAIL b2b_interval: got %0d want %0d", second - first, NCHUNK + 2);
        end
        for (int i = 0; i < NCHUNK + 2; i++) step();
        out_ready = 1'b0;
        n_cmp++;
        if (q !== 16'h1000 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_result: q=%h in_ready=%b, want 1000 1", q, in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_reset_midrun();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
